mult8_pp_sequencer: RTL
=======================

Name: mult8_pp_sequencer

Overview:
Sequencing controller for the split-operand 8x8 approximate multiplier. Each operand splits into high (HI_W) and low (LO_W) fields. The block time-multiplexes one shared HI_W x HI_W partial-product unit over the HH, HL, LH and LL terms and accumulates them with the correct shifts. A per-transaction approximation mode skips low-order terms, which cuts both latency and accuracy. It sits between an operand-producing stage and a result consumer, with valid/ready on both sides.

Parameters:
LO_W, 2, low-field width (legal 1..4); HI_W = 8 - LO_W is derived, not overridable
ACC_W, 16, accumulator and result width (fixed at 2*8; present for the package constant only)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand transaction offered
in_ready  out  1  block can accept operands
a  in  8  multiplicand
b  in  8  multiplier
mode  in  2  0 = exact (HH, HL, LH, LL); 1 = skip LL; 2/3 = HH only
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
p  out  16  product (exact or approximate per mode)
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; in_ready=1; out_valid=0; p=0; busy=0; accumulator and operand registers cleared. This applies mid-operation too: the in-flight transaction is discarded and no output is produced.
- Split: AH=a[7:LO_W], AL=a[LO_W-1:0], same for b. Low fields are zero-extended to HI_W before they enter the shared unit.
- FSM states: IDLE, HH, HL, LH, LL, DONE. One cycle per term state.
- IDLE: in_ready=1. When in_valid&in_ready, register a, b and mode (mode 3 is stored as 2), clear acc, go to HH. in_ready=0 in every other state; in_valid offered while busy is ignored and not queued.
- HH: acc += (AH*BH) << (2*LO_W). Next state is HL for mode 0/1, DONE for mode 2.
- HL: acc += (AH*BL) << LO_W. Next state is LH.
- LH: acc += (AL*BH) << LO_W. Next state is LL for mode 0, DONE for mode 1.
- LL: acc += AL*BL. Next state is DONE.
- DONE: p=acc (registered on entry), out_valid=1.
  - p and out_valid hold stable while out_ready=0.
  - When out_ready=1, go to IDLE next cycle; out_valid drops and in_ready rises in that cycle.
- Latency, from accept edge to the first cycle with out_valid=1: mode 0 = 5 cycles, mode 1 = 4, mode 2 = 2. Accept-to-accept throughput is latency + 1 (+ any stall cycles).
- Arithmetic: all sums are unsigned in 16 bits. Exact mode never overflows (max 255*255=65025). Approximate results are always <= the exact result.
- out_ready high while out_valid=0 has no effect. Back-to-back: a new operand cannot be accepted in the same cycle a result is consumed.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs ops_done[15:0] and stall_cycles[15:0].
  - ops_done increments on each out_valid&out_ready.
  - stall_cycles increments on each cycle with out_valid&!out_ready.
  - Both saturate at 16'hFFFF and are cleared by rst_n.
- Not defined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Package mult8_pkg:
  - state enum (IDLE, HH, HL, LH, LL, DONE)
  - mode encoding constants MODE_EXACT=0, MODE_NO_LL=1, MODE_HH_ONLY=2
  - LO_W/HI_W defaults and ACC_W
- Sub-module pp_mul_hh: the shared combinational HI_W x HI_W unsigned multiplier, output 2*HI_W bits, instantiated once. Operand-select muxes stay in the controller.

Test Plan:
- Reset idle check: rst_n low then high, no stimulus -> in_ready=1, out_valid=0, p=0, busy=0.
- Exact mode: a=203, b=151, mode=0, out_ready=1 -> p=30653, out_valid exactly 5 cycles after accept, held 1 cycle.
- Mode 1: a=203, b=151, mode=1 -> p=30644 (LL term 9 dropped), latency 4. Mode 2/3 with the same operands -> p=29600, latency 2.
- Backpressure: a=255, b=255, mode=0, out_ready held 0 for 7 cycles -> p=65025 stable, out_valid held, in_ready=0 throughout. With PERF_CNT_EN: stall_cycles=7, ops_done=1 after release.
- Busy and reset mid-op: accept a=17, b=9, then drive in_valid with a=100, b=100 during the term states -> second transaction not accepted. Assert rst_n=0 in state LH -> immediate IDLE outputs, no out_valid. Next accept of a=17, b=9 gives p=153.

Source files
------------

// File: rtl/mult8_pkg.sv
// Shared types and constants for the split-operand 8x8 multiplier sequencer.
package mult8_pkg;

  localparam int LO_W_DEF = 2;
  localparam int HI_W_DEF = 8 - LO_W_DEF;
  localparam int ACC_W    = 16;

  localparam logic [1:0] MODE_EXACT   = 2'd0;
  localparam logic [1:0] MODE_NO_LL   = 2'd1;
  localparam logic [1:0] MODE_HH_ONLY = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    HH,
    HL,
    LH,
    LL,
    DONE
  } state_t;

  // Mode 3 behaves as HH-only, so fold it into one encoding at capture time.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_HH_ONLY : m;
  endfunction

endpackage

// File: rtl/mult8_pp_sequencer_pp_mul_hh.sv
// Shared combinational HI_W x HI_W unsigned partial-product multiplier.
module pp_mul_hh
  import mult8_pkg::*;
#(
  parameter int HI_W = HI_W_DEF
) (
  input  logic [HI_W-1:0]   x,
  input  logic [HI_W-1:0]   y,
  output logic [2*HI_W-1:0] prod
);

  localparam int PW = 2 * HI_W;

  assign prod = PW'(x) * PW'(y);

endmodule

// File: rtl/mult8_pp_sequencer.sv
// Time-multiplexed 8x8 multiplier controller with per-transaction approximation modes.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module mult8_pp_sequencer
  import mult8_pkg::*;
#(
  parameter int LO_W = LO_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] p,
`ifdef PERF_CNT_EN
  output logic [15:0]      ops_done,
  output logic [15:0]      stall_cycles,
`endif
  output logic             busy
);

  localparam int HI_W = 8 - LO_W;
  localparam int PW   = 2 * HI_W;

  state_t           state_q, state_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] p_q, p_d;

  logic [HI_W-1:0]  ah, bh, al_ext, bl_ext;
  logic [HI_W-1:0]  op_x, op_y;
  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] term;

  assign ah     = a_q[7:LO_W];
  assign bh     = b_q[7:LO_W];
  assign al_ext = HI_W'(a_q[LO_W-1:0]);
  assign bl_ext = HI_W'(b_q[LO_W-1:0]);

  pp_mul_hh #(.HI_W(HI_W)) u_mul (
    .x    (op_x),
    .y    (op_y),
    .prod (prod)
  );

  assign prod_ext = ACC_W'(prod);

  // Operand selection and alignment of the current term into accumulator weight.
  always_comb begin
    op_x = ah;
    op_y = bh;
    term = '0;
    case (state_q)
      HH: begin
        op_x = ah;
        op_y = bh;
        term = prod_ext << (2 * LO_W);
      end
      HL: begin
        op_x = ah;
        op_y = bl_ext;
        term = prod_ext << LO_W;
      end
      LH: begin
        op_x = al_ext;
        op_y = bh;
        term = prod_ext << LO_W;
      end
      LL: begin
        op_x = al_ext;
        op_y = bl_ext;
        term = prod_ext;
      end
      default: term = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mode_d  = norm_mode(mode);
          acc_d   = '0;
          state_d = HH;
        end
      end
      HH: begin
        acc_d   = acc_q + term;
        state_d = (mode_q == MODE_HH_ONLY) ? DONE : HL;
      end
      HL: begin
        acc_d   = acc_q + term;
        state_d = LH;
      end
      LH: begin
        acc_d   = acc_q + term;
        state_d = (mode_q == MODE_EXACT) ? LL : DONE;
      end
      LL: begin
        acc_d   = acc_q + term;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Result register captures the final sum on the way into DONE.
    if (state_d == DONE && state_q != DONE) p_d = acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_EXACT;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p         = p_q;

`ifdef PERF_CNT_EN
  logic [15:0] ops_q, ops_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    ops_d   = ops_q;
    stall_d = stall_q;
    if (out_valid && out_ready && ops_q != 16'hFFFF) ops_d = ops_q + 16'd1;
    if (out_valid && !out_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      ops_q   <= ops_d;
      stall_q <= stall_d;
    end
  end

  assign ops_done     = ops_q;
  assign stall_cycles = stall_q;
`endif

endmodule
